// File: rtl/rpn_stack_sequencer.sv
// rpn_stack_sequencer
//   Postfix (RPN) expression sequencer placed directly in front of an
//   overflow/underflow-detecting stack. Operand tokens are pushed; operator
//   tokens pop B then A, compute A op B and push the result. Any stack error
//   or illegal opcode parks the block in a sticky ERR state until err_clr.
//
//   Optional feature macro: RPN_MUL_EN (opcode 101 = A*B, low DATA_WIDTH bits).
//   Without it opcode 101 is treated as illegal.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   tok_valid/ready     token handshake; a token is taken when both are 1
//   tok_is_op, tok_data 1 = operator (opcode in tok_data[2:0]), 0 = operand
//   stk_push/pop/wdata  one-cycle strobes and write data toward the stack
//   stk_rdata           stack data_out, valid the cycle after stk_pop
//   stk_overflow/under  stack error pulses, the cycle after a rejected access
//   res_valid/res_data  pulse when an operator result is safely on the stack
//   err, err_code       sticky error (01 ovf, 10 unf, 11 illegal opcode)
//   err_clr             leaves ERR and returns to IDLE
//   ops_done            saturating count of successful operator evaluations
//   fsm_state           current state, for observation
//   opnd_a, opnd_b      operand registers A and B, for observation
//
// Handshake: tok_ready is a registered output that is 1 only while the FSM
// sits in IDLE without an error; tok_valid may be held high, and exactly one
// token is consumed per IDLE visit.
module rpn_stack_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tok_valid,
   output logic                  tok_ready,
   input  logic                  tok_is_op,
   input  logic [DATA_WIDTH-1:0] tok_data,
   output logic                  stk_push,
   output logic                  stk_pop,
   output logic [DATA_WIDTH-1:0] stk_wdata,
   input  logic [DATA_WIDTH-1:0] stk_rdata,
   input  logic                  stk_overflow,
   input  logic                  stk_underflow,
   output logic                  res_valid,
   output logic [DATA_WIDTH-1:0] res_data,
   output logic                  err,
   output logic [1:0]            err_code,
   input  logic                  err_clr,
   output logic [CNT_WIDTH-1:0]  ops_done,
   output logic [2:0]            fsm_state,
   output logic [DATA_WIDTH-1:0] opnd_a,
   output logic [DATA_WIDTH-1:0] opnd_b
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_POP_B  = 3'd1;
   localparam logic [2:0] S_WAIT_B = 3'd2;
   localparam logic [2:0] S_POP_A  = 3'd3;
   localparam logic [2:0] S_WAIT_A = 3'd4;
   localparam logic [2:0] S_PUSH   = 3'd5;
   localparam logic [2:0] S_CHECK  = 3'd6;
   localparam logic [2:0] S_ERR    = 3'd7;

   localparam logic [1:0] E_OVF = 2'b01;
   localparam logic [1:0] E_UNF = 2'b10;
   localparam logic [1:0] E_ILL = 2'b11;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [2:0] state;
   logic [2:0] opcode;
   logic       result_push;   // current PUSH carries an operator result

   function automatic logic legal_op(input logic [2:0] op);
`ifdef RPN_MUL_EN
      legal_op = (op <= 3'b101);
`else
      legal_op = (op <= 3'b100);
`endif
   endfunction

   function automatic logic [DATA_WIDTH-1:0] alu(input logic [2:0] op,
                                                  input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
      case (op)
         3'b000:  alu = a + b;
         3'b001:  alu = a - b;
         3'b010:  alu = a & b;
         3'b011:  alu = a | b;
         3'b100:  alu = a ^ b;
`ifdef RPN_MUL_EN
         3'b101:  alu = a * b;
`endif
         default: alu = '0;
      endcase
   endfunction

   assign fsm_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         opcode      <= 3'b000;
         result_push <= 1'b0;
         tok_ready   <= 1'b0;
         stk_push    <= 1'b0;
         stk_pop     <= 1'b0;
         stk_wdata   <= '0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         err         <= 1'b0;
         err_code    <= 2'b00;
         ops_done    <= '0;
         opnd_a      <= '0;
         opnd_b      <= '0;
      end else begin
         // Strobes are single-cycle unless a state sets them below.
         stk_push  <= 1'b0;
         stk_pop   <= 1'b0;
         res_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (tok_valid && tok_ready) begin
                  tok_ready <= 1'b0;
                  if (!tok_is_op) begin
                     stk_wdata   <= tok_data;
                     stk_push    <= 1'b1;
                     result_push <= 1'b0;
                     state       <= S_PUSH;
                  end else if (legal_op(tok_data[2:0])) begin
                     opcode  <= tok_data[2:0];
                     stk_pop <= 1'b1;
                     state   <= S_POP_B;
                  end else begin
                     err      <= 1'b1;
                     err_code <= E_ILL;
                     state    <= S_ERR;
                  end
               end else begin
                  // Also covers the first cycle after reset release.
                  tok_ready <= 1'b1;
               end
            end
            S_POP_B: state <= S_WAIT_B;
            S_WAIT_B: begin
               opnd_b <= stk_rdata;
               if (stk_underflow) begin
                  err      <= 1'b1;
                  err_code <= E_UNF;
                  state    <= S_ERR;
               end else begin
                  stk_pop <= 1'b1;
                  state   <= S_POP_A;
               end
            end
            S_POP_A: state <= S_WAIT_A;
            S_WAIT_A: begin
               opnd_a <= stk_rdata;
               if (stk_underflow) begin
                  err      <= 1'b1;
                  err_code <= E_UNF;
                  state    <= S_ERR;
               end else begin
                  // A arrives this cycle, so compute from stk_rdata directly.
                  stk_wdata   <= alu(opcode, stk_rdata, opnd_b);
                  stk_push    <= 1'b1;
                  result_push <= 1'b1;
                  state       <= S_PUSH;
               end
            end
            S_PUSH: state <= S_CHECK;
            S_CHECK: begin
               if (stk_overflow) begin
                  err      <= 1'b1;
                  err_code <= E_OVF;
                  state    <= S_ERR;
               end else begin
                  state     <= S_IDLE;
                  tok_ready <= 1'b1;
                  if (result_push) begin
                     res_valid <= 1'b1;
                     res_data  <= stk_wdata;
                     if (ops_done != {CNT_WIDTH{1'b1}})
                        ops_done <= ops_done + CNT_ONE;
                  end
               end
            end
            S_ERR: begin
               if (err_clr) begin
                  err       <= 1'b0;
                  err_code  <= 2'b00;
                  state     <= S_IDLE;
                  tok_ready <= 1'b1;
               end
            end
            default: begin
               state     <= S_IDLE;
               tok_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rpn_stack_sequencer.sv
// Self-checking bench for rpn_stack_sequencer: a 16-deep stack model sits on
// the stack side, a queue-based RPN reference model predicts results/errors,
// and a monitor compares each res_valid / err event against the prediction.
module tb_rpn_stack_sequencer;
   localparam int DW    = 8;
   localparam int CW    = 16;
   localparam int DEPTH = 16;

   logic          clk;
   logic          rst_n;
   logic          tok_valid;
   logic          tok_ready;
   logic          tok_is_op;
   logic [DW-1:0] tok_data;
   logic          stk_push;
   logic          stk_pop;
   logic [DW-1:0] stk_wdata;
   logic [DW-1:0] stk_rdata;
   logic          stk_overflow;
   logic          stk_underflow;
   logic          res_valid;
   logic [DW-1:0] res_data;
   logic          err;
   logic [1:0]    err_code;
   logic          err_clr;
   logic [CW-1:0] ops_done;
   logic [2:0]    fsm_state;
   logic [DW-1:0] opnd_a;
   logic [DW-1:0] opnd_b;

   rpn_stack_sequencer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .tok_valid(tok_valid), .tok_ready(tok_ready),
      .tok_is_op(tok_is_op), .tok_data(tok_data),
      .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata),
      .stk_rdata(stk_rdata), .stk_overflow(stk_overflow), .stk_underflow(stk_underflow),
      .res_valid(res_valid), .res_data(res_data),
      .err(err), .err_code(err_code), .err_clr(err_clr),
      .ops_done(ops_done), .fsm_state(fsm_state),
      .opnd_a(opnd_a), .opnd_b(opnd_b)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- counters ----------------
   int checks = 0;
   int errors = 0;
   int act_push = 0, act_pop = 0, collide = 0;
   int exp_push = 0, exp_pop = 0;
   int exp_ops = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ---------------- stack model (environment) ----------------
   logic [DW-1:0] stk_mem[$];
   initial begin
      stk_rdata = '0; stk_overflow = 1'b0; stk_underflow = 1'b0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            stk_mem.delete();
            stk_rdata <= '0; stk_overflow <= 1'b0; stk_underflow <= 1'b0;
         end else begin
            stk_overflow  <= 1'b0;
            stk_underflow <= 1'b0;
            if (stk_push) begin
               if (stk_mem.size() < DEPTH) stk_mem.push_back(stk_wdata);
               else stk_overflow <= 1'b1;
            end else if (stk_pop) begin
               if (stk_mem.size() > 0) stk_rdata <= stk_mem.pop_back();
               else stk_underflow <= 1'b1;
            end
         end
      end
   end

   // ---------------- reference model ----------------
   // entry = {kind[1:0] (00 result, else err code), data[7:0], ops_done[15:0]}
   logic [25:0]   exp_q[$];
   logic [DW-1:0] ref_stk[$];

   function automatic logic ref_legal(input logic [2:0] op);
`ifdef RPN_MUL_EN
      return op <= 3'd5;
`else
      return op <= 3'd4;
`endif
   endfunction

   function automatic logic [DW-1:0] ref_calc(input logic [2:0] op, input int a, input int b);
      int r;
      case (op)
         3'd0: r = a + b;
         3'd1: r = a - b + 256;
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         default: r = a * b;
      endcase
      return DW'(r % 256);
   endfunction

   // Returns 1 when the token is expected to end in an error.
   function automatic logic ref_step(input logic is_op, input logic [DW-1:0] d);
      logic [DW-1:0] a, b;
      if (!is_op) begin
         exp_push++;
         if (ref_stk.size() < DEPTH) begin
            ref_stk.push_back(d);
            return 1'b0;
         end
         exp_q.push_back({2'b01, 8'h00, 16'(exp_ops)});
         return 1'b1;
      end
      if (!ref_legal(d[2:0])) begin
         exp_q.push_back({2'b11, 8'h00, 16'(exp_ops)});
         return 1'b1;
      end
      if (ref_stk.size() == 0) begin
         exp_pop += 1;
         exp_q.push_back({2'b10, 8'h00, 16'(exp_ops)});
         return 1'b1;
      end
      if (ref_stk.size() == 1) begin
         exp_pop += 2;
         void'(ref_stk.pop_back());
         exp_q.push_back({2'b10, 8'h00, 16'(exp_ops)});
         return 1'b1;
      end
      b = ref_stk.pop_back();
      a = ref_stk.pop_back();
      ref_stk.push_back(ref_calc(d[2:0], int'(a), int'(b)));
      exp_pop  += 2;
      exp_push += 1;
      if (exp_ops < 65535) exp_ops++;
      exp_q.push_back({2'b00, ref_calc(d[2:0], int'(a), int'(b)), 16'(exp_ops)});
      return 1'b0;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   task automatic score(input logic [1:0] kind, input logic [DW-1:0] data);
      logic [25:0] e;
      if (exp_q.size() == 0) begin
         chk("unexpected_event", {30'd0, kind}, 32'hFFFF_FFFF);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", 32'(kind), 32'(e[25:24]));
         if (kind == 2'b00) chk("res_data", 32'(data), 32'(e[23:16]));
         chk("ops_done", 32'(ops_done), 32'(e[15:0]));
      end
   endtask

   initial begin
      logic err_seen;
      err_seen = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            err_seen = 1'b0;
         end else begin
            if (stk_push) act_push++;
            if (stk_pop) act_pop++;
            if (stk_push && stk_pop) collide++;
            if (res_valid) score(2'b00, res_data);
            if (err && !err_seen) score(err_code, '0);
            err_seen = err;
         end
      end
   end

   // ---------------- driver tasks (called at a negedge) ----------------
   task automatic issue(input logic is_op, input logic [DW-1:0] d);
      logic will_err;
      int n;
      will_err  = ref_step(is_op, d);
      tok_valid = 1'b1;
      tok_is_op = is_op;
      tok_data  = d;
      n = 0;
      while (!tok_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!tok_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         tok_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      if (will_err) begin
         tok_valid = 1'b0;
         n = 0;
         while (!err && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("err_raised", 32'(err), 32'd1);
         @(negedge clk);
         chk("ready_low_in_err", 32'(tok_ready), 32'd0);
         err_clr = 1'b1;
         @(negedge clk);
         err_clr = 1'b0;
         chk("err_cleared", {29'd0, err, err_code}, 32'd0);
      end
   endtask

   task automatic do_reset(input logic check_counts);
      if (check_counts) begin
         chk("push_count", 32'(act_push), 32'(exp_push));
         chk("pop_count", 32'(act_pop), 32'(exp_pop));
      end
      rst_n = 1'b0;
      tok_valid = 1'b0;
      #1;
      chk("reset_ctrl", {20'd0, stk_push, stk_pop, res_valid, err, err_code, tok_ready, fsm_state == 3'd0}, 32'd1);
      chk("reset_data", {stk_wdata, res_data, opnd_a, opnd_b}, 32'd0);
      chk("reset_ops", 32'(ops_done), 32'd0);
      ref_stk.delete();
      exp_q.delete();
      act_push = 0; act_pop = 0; exp_push = 0; exp_pop = 0; exp_ops = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_reset", 32'(tok_ready), 32'd1);
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      tok_valid = 1'b0;
      n = 0;
      while ((exp_q.size() != 0 || !tok_ready) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b0; tok_valid = 1'b0; tok_is_op = 1'b0; tok_data = '0; err_clr = 1'b0;
      @(negedge clk);
      do_reset(1'b0);

      // Basic arithmetic, including wraparound.
      issue(0, 8'd5);   issue(0, 8'd3);   issue(1, 8'd0);
      issue(0, 8'd2);   issue(0, 8'd7);   issue(1, 8'd1);
      issue(0, 8'hF0);  issue(0, 8'h20);  issue(1, 8'd0);
      issue(1, 8'd3);   issue(1, 8'd4);
      drain();

      // Second pop underflows, then first pop underflows on empty stack.
      do_reset(1'b1);
      issue(0, 8'd4);   issue(1, 8'd0);
      issue(1, 8'd2);
      drain();

      // Full stack then one more operand; then illegal opcodes and 101.
      do_reset(1'b1);
      for (int i = 0; i < DEPTH; i++) issue(0, 8'($urandom_range(0, 255)));
      issue(0, 8'd9);
      issue(1, 8'd6);
      issue(1, 8'd7);
      issue(1, 8'd0);
      issue(0, 8'd6);   issue(0, 8'd7);   issue(1, 8'd5);
      drain();

      // Reset while the operator is in WAIT_A.
      do_reset(1'b1);
      issue(0, 8'd1);   issue(0, 8'd2);   issue(1, 8'd0);
      tok_valid = 1'b0;
      @(negedge clk); @(negedge clk); @(negedge clk);
      chk("pops_before_reset", 32'(act_pop), 32'd2);
      do_reset(1'b0);

      // Random token stream with tok_valid held high between tokens.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) < 60) issue(0, 8'($urandom));
         else issue(1, 8'($urandom_range(0, 7)));
      end
      drain();

      chk("final_push_count", 32'(act_push), 32'(exp_push));
      chk("final_pop_count", 32'(act_pop), 32'(exp_pop));
      chk("push_pop_collision", 32'(collide), 32'd0);
      chk("final_ops_done", 32'(ops_done), 32'(exp_ops));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule
